alu_op_sequencer: RTL



---
 rtl/alu_op_sequencer_if.sv | 27 ++
 rtl/alu_op_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer_if.sv
// Bus between the main control FSM (master) and the ALU op sequencer (slave):
// instruction fields, operands and start in; ALU code, status and M-op result out.
interface alu_op_sequencer_if #(parameter int XLEN = 32);
  logic [1:0]      ALUOp;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [6:0]      opcode;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            start;
  logic [3:0]      alu_ctrl;
  logic            is_muldiv;
  logic            illegal_op;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] md_result;

  modport master (
    output ALUOp, funct3, funct7, opcode, operand_a, operand_b, start,
    input  alu_ctrl, is_muldiv, illegal_op, busy, done, md_result
  );

  modport slave (
    input  ALUOp, funct3, funct7, opcode, operand_a, operand_b, start,
    output alu_ctrl, is_muldiv, illegal_op, busy, done, md_result
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// ALU control decoder plus iterative RV32M/RV64M sequencer (shift-add multiply,
// restoring divide). Define ALU_SEQ_DIV_EN to build the divider and enable DIV/REM ops.
module alu_op_sequencer #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_op_sequencer_if.slave bus
);
  localparam int CW = $clog2(XLEN) + 1;

  localparam logic [3:0] A_ADD = 4'b0000, A_SUB = 4'b0001, A_SLL = 4'b0010,
                         A_SLT = 4'b0011, A_SLTU = 4'b0100, A_XOR = 4'b0101,
                         A_OR  = 4'b0110, A_AND = 4'b0111, A_SRL = 4'b1000,
                         A_SRA = 4'b1001;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIN = 2'd2} state_e;

  logic       mop_raw, mop_ok, illegal;
  logic [3:0] ctrl;

  always_comb begin
    mop_raw = (bus.ALUOp == 2'b10) && (bus.opcode == 7'b0110011) &&
              (bus.funct7 == 7'b0000001);
`ifdef ALU_SEQ_DIV_EN
    mop_ok  = mop_raw;
    illegal = 1'b0;
`else
    mop_ok  = mop_raw && !bus.funct3[2];
    illegal = mop_raw && bus.funct3[2];
`endif
    ctrl = A_ADD;
    case (bus.ALUOp)
      2'b01: ctrl = A_SUB;
      2'b10: begin
        // M-ops (supported or not) leave the ALU on ADD
        if (!mop_raw) begin
          case (bus.funct3)
            3'b000:  ctrl = (bus.funct7 == 7'b0100000 && bus.opcode[5]) ? A_SUB : A_ADD;
            3'b001:  ctrl = A_SLL;
            3'b010:  ctrl = A_SLT;
            3'b011:  ctrl = A_SLTU;
            3'b100:  ctrl = A_XOR;
            3'b101:  ctrl = (bus.funct7 == 7'b0100000) ? A_SRA : A_SRL;
            3'b110:  ctrl = A_OR;
            default: ctrl = A_AND;
          endcase
        end
      end
      default: ctrl = A_ADD;
    endcase
  end

  assign bus.alu_ctrl   = ctrl;
  assign bus.is_muldiv  = mop_ok;
  assign bus.illegal_op = illegal;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic            neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic [XLEN-1:0] acc_q, acc_d, lo_q, lo_d, mcand_q, mcand_d, res_q, res_d;
  logic            busy_q, busy_d, done_q, done_d;
`ifdef ALU_SEQ_DIV_EN
  logic            bzero_q, bzero_d;
`endif

  // operand magnitudes and signs captured at start
  logic            sgn_a, sgn_b, na, nb;
  logic [XLEN-1:0] abs_a, abs_b;

  always_comb begin
    sgn_a = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
            (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    sgn_b = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    na    = sgn_a && bus.operand_a[XLEN-1];
    nb    = sgn_b && bus.operand_b[XLEN-1];
    abs_a = na ? -bus.operand_a : bus.operand_a;
    abs_b = nb ? -bus.operand_b : bus.operand_b;
  end

  // acc:lo is the product (high:low) for multiply, remainder:quotient for divide
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   mul_acc, mul_lo, div_acc, div_lo, step_acc, step_lo;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   mul_res, div_res, fin_res;
`ifdef ALU_SEQ_DIV_EN
  logic [XLEN:0]     div_sh, div_diff;
  logic [XLEN-1:0]   quo, rem;
`endif

  always_comb begin
    mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
    mul_acc = mul_sum[XLEN:1];
    mul_lo  = {mul_sum[0], lo_q[XLEN-1:1]};
    prod    = {acc_q, lo_q};
    if (neg_a_q ^ neg_b_q) prod = -prod;
    mul_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`ifdef ALU_SEQ_DIV_EN
    div_sh   = {acc_q, lo_q[XLEN-1]};
    div_diff = div_sh - {1'b0, mcand_q};
    if (!div_diff[XLEN]) begin
      div_acc = div_diff[XLEN-1:0];
      div_lo  = {lo_q[XLEN-2:0], 1'b1};
    end else begin
      div_acc = div_sh[XLEN-1:0];
      div_lo  = {lo_q[XLEN-2:0], 1'b0};
    end
    quo = (neg_a_q ^ neg_b_q) ? -lo_q : lo_q;
    if (bzero_q) quo = '1;
    rem = neg_a_q ? -acc_q : acc_q;
    div_res = op_q[1] ? rem : quo;
`else
    div_acc = acc_q;
    div_lo  = lo_q;
    div_res = '0;
`endif
    step_acc = op_q[2] ? div_acc : mul_acc;
    step_lo  = op_q[2] ? div_lo  : mul_lo;
    fin_res  = op_q[2] ? div_res : mul_res;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    mcand_d = mcand_q;
    res_d   = res_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef ALU_SEQ_DIV_EN
    bzero_d = bzero_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start && mop_ok) begin
          state_d = S_RUN;
          cnt_d   = CW'(XLEN);
          op_d    = bus.funct3;
          neg_a_d = na;
          neg_b_d = nb;
          acc_d   = '0;
          lo_d    = abs_a;
          mcand_d = abs_b;
          busy_d  = 1'b1;
`ifdef ALU_SEQ_DIV_EN
          bzero_d = (bus.operand_b == '0);
`endif
        end
      end
      S_RUN: begin
        acc_d = step_acc;
        lo_d  = step_lo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIN;
      end
      S_FIN: begin
        res_d   = fin_res;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      acc_q   <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      bzero_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      mcand_q <= mcand_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef ALU_SEQ_DIV_EN
      bzero_q <= bzero_d;
`endif
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.md_result = res_q;
endmodule
